// File: rtl/masc_wb_scheduler_if.sv
// masc_wb_scheduler_if: Wishbone slave bus bundle for the execute scheduler
interface masc_wb_scheduler_if;
  logic        stb;
  logic        cyc;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic        ack;
  logic [31:0] rdat;
  modport master (output stb, cyc, we, sel, adr, wdat, input ack, rdat);
  modport slave (input stb, cyc, we, sel, adr, wdat, output ack, rdat);
endinterface

// File: rtl/masc_wb_scheduler.sv
// masc_wb_scheduler: Wishbone front end issuing credited ops into the execute pipeline and queueing results
module masc_wb_scheduler #(
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
  parameter int LAT = 5,
  parameter int RES_DEPTH = 8
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  masc_wb_scheduler_if.slave  wb,
  output logic                exe_valid,
  output logic [31:0]         exe_instruction,
  output logic [31:0]         exe_rs1,
  output logic [31:0]         exe_rs2,
  output logic [7:0]          exe_bs,
  input  logic [32:0]         exe_out,
  output logic                irq
);
  localparam int AW = $clog2(RES_DEPTH);
  localparam int CW = AW + 1;
  logic [31:0] rs1, rs2, insn;
  logic [7:0] bs;
  logic irq_en, lat_err, underflow;
  logic [LAT-1:0] sr;
  logic [CW-1:0] inflight, cnt;
  logic [AW-1:0] wp, rp;
  logic [31:0] mem [RES_DEPTH];
  logic hit, req, is_insn, credit, acc, wr, rd, issue, pop, uf_set, push;
  logic [2:0] sel;
  logic [CW:0] used;
  logic [1:0] clr;
  logic [31:0] status, rd_val, push_dat;
  logic unused_ok;
  assign unused_ok = ^{wb.sel, wb.adr[1:0]};
  assign exe_rs1 = rs1;
  assign exe_rs2 = rs2;
  assign exe_bs = bs;
  assign exe_instruction = insn;
  always_comb begin
    hit = wb.adr[31:5] == ADDR_BASE[31:5];
    sel = wb.adr[4:2];
    req = wb.stb & wb.cyc & ~wb.ack;
    used = {1'b0, inflight} + {1'b0, cnt};
    credit = used < (CW+1)'(RES_DEPTH);
    is_insn = hit & wb.we & (sel == 3'd3);
    acc = req & (~is_insn | credit);
    wr = acc & hit & wb.we;
    rd = acc & hit & ~wb.we;
    issue = acc & is_insn;
    pop = rd & (sel == 3'd5) & (cnt != '0);
    uf_set = rd & (sel == 3'd5) & (cnt == '0);
    push = sr[LAT-1];
    push_dat = exe_out[32] ? exe_out[31:0] : '0;
    clr = (wr & (sel == 3'd4)) ? wb.wdat[4:3] : 2'b00;
    status = {11'b0, 5'(cnt), 4'b0, 4'(inflight), 3'b0, underflow, lat_err,
              cnt == CW'(RES_DEPTH), cnt == '0, inflight != '0};
    rd_val = sel == 3'd0 ? rs1 :
             sel == 3'd1 ? rs2 :
             sel == 3'd2 ? {24'b0, bs} :
             sel == 3'd3 ? insn :
             sel == 3'd4 ? status :
             sel == 3'd5 ? (cnt != '0 ? mem[rp] : '0) :
             sel == 3'd6 ? {31'b0, irq_en} : '0;
  end
  always_ff @(posedge wb_clk_i)
    if (push) mem[wp] <= push_dat;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb.ack <= 1'b0;
      wb.rdat <= '0;
      exe_valid <= 1'b0;
      {rs1, rs2, insn, bs, irq_en} <= '0;
      {lat_err, underflow, irq} <= '0;
      sr <= '0;
      {inflight, cnt, wp, rp} <= '0;
    end else begin
      wb.ack <= acc;
      exe_valid <= issue;
      if (acc) wb.rdat <= rd ? rd_val : '0;
      if (wr && sel == 3'd0) rs1 <= wb.wdat;
      if (wr && sel == 3'd1) rs2 <= wb.wdat;
      if (wr && sel == 3'd2) bs <= wb.wdat[7:0];
      if (wr && sel == 3'd3) insn <= wb.wdat;
      if (wr && sel == 3'd6) irq_en <= wb.wdat[0];
      sr <= {sr[LAT-2:0], exe_valid};
      inflight <= inflight + CW'(issue) - CW'(push);
      cnt <= cnt + CW'(push) - CW'(pop);
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      lat_err <= (lat_err & ~clr[0]) | (push & ~exe_out[32]);
      underflow <= (underflow & ~clr[1]) | uf_set;
      irq <= irq_en & (cnt != '0);
    end
  end
endmodule

// File: doc/masc_wb_scheduler.md
Name: masc_wb_scheduler

Overview:
Wishbone-slave front end that sequences operations into the 5-stage `__masc__execute` accelerator in place of direct logic-analyzer driving.
- Software writes operands and the instruction to registers; the block issues one-cycle valid pulses into the pipeline, tracks in-flight operations with credits, and collects results into a result FIFO that software pops.
- Sits inside `user_proj_example` between the Wishbone slave port and the execute unit; also drives an IRQ.

Parameters:
- ADDR_BASE, 32'h3000_0000, Wishbone base address; decode is `wbs_adr_i[31:5] == ADDR_BASE[31:5]`.
- LAT, 5, execute pipeline latency in cycles (valid-in to valid-out).
- RES_DEPTH, 8, result FIFO depth (power of two, 2..16).

Ports:
- wb_clk_i  in  1  single clock, rising edge
- wb_rst_i  in  1  reset, synchronous, active-high
- wbs_stb_i  in  1  Wishbone strobe
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte select; ignored, all accesses are full-word
- wbs_dat_i  in  32  write data
- wbs_adr_i  in  32  address
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- exe_valid  out  1  valid input to execute
- exe_instruction  out  32  opcode (0..23)
- exe_rs1  out  32  operand 1
- exe_rs2  out  32  operand 2
- exe_bs  out  8  byte select
- exe_out  in  33  execute result; bit 32 is valid
- irq  out  1  result-available interrupt

Behaviour:
- Register map, word offset `adr[4:2]`:
  - 0 RS1 RW
  - 1 RS2 RW
  - 2 BS RW ([7:0]; upper bits read 0)
  - 3 INSN W: issue request; reads last INSN
  - 4 STATUS RO, W1C on sticky bits
  - 5 RESULT RO: pops the FIFO
  - 6 IRQ_EN RW ([0])
  - 7 reserved: reads 0, writes ignored
- STATUS fields:
  - [0] busy (inflight != 0)
  - [1] res_empty
  - [2] res_full
  - [3] lat_err sticky
  - [4] underflow sticky
  - [11:8] inflight count
  - [20:16] res_count
  - other bits 0
- Reset values: all registers 0, FIFO empty, inflight 0, `wbs_ack_o`=0, `wbs_dat_o`=0, `exe_valid`=0, `exe_*` buses 0, `irq`=0.
- Wishbone ack:
  - Registered; `wbs_ack_o` pulses 1 cycle after `stb&cyc`, for exactly one cycle.
  - `wbs_ack_o` is low in the cycle after any ack, so back-to-back requests each get a fresh ack.
  - Out-of-range address: ack, read 0, no side effect.
- Credit rule: an issue is allowed only when `inflight + res_count < RES_DEPTH`. A pop in the same cycle is not credited until the next cycle.
- INSN write:
  - Credit available: ack next cycle; in that same ack cycle `exe_valid`=1 for exactly one cycle, with `exe_rs1/rs2/bs/instruction` = register values (new INSN value); inflight++.
  - No credit: ack is withheld (wait states) until credit is available, then issue and ack together.
- Tracking: an LAT-deep shift register of expected-valid bits is loaded with 1 on issue. When the bit exits (issue cycle + LAT):
  - `exe_out[32]`=1: push `exe_out[31:0]` to the FIFO and decrement inflight.
  - `exe_out[32]`=0: set lat_err, push 0, decrement inflight.
  - `exe_out[32]`=1 with no expected bit (e.g. leftovers from before reset) is ignored.
- RESULT read:
  - FIFO not empty: returns head and pops on the ack cycle.
  - FIFO empty: returns 0, no pop, sets underflow.
  - Push and pop in the same cycle: both occur; count unchanged.
- FIFO pointers wrap modulo RES_DEPTH. Overflow cannot occur because of the credit rule.
- W1C: a STATUS write clears each sticky bit written with 1. A set event in the same cycle wins over the clear.
- `irq` = `IRQ_EN[0] & ~res_empty`, registered (one-cycle delay).
- Reset mid-operation:
  - Shift register, inflight, FIFO and stickies are cleared.
  - A pending stalled INSN write is dropped with no ack.
  - Pipeline outputs arriving after reset are ignored.

Test Plan:
- RS1=0x0000_0001, RS2=1, INSN=0 (ROR) → `exe_valid` pulses once; LAT cycles later res_count=1; RESULT read = 0x8000_0000; STATUS[1]=1 afterwards.
- RS1=0xFFFF_0000, RS2=0x0F0F_0F0F, INSN=5 (XNOR) issued 8 times back-to-back → 9th INSN write stalls ack until a RESULT pop; every pop = 0x0F0F_F0F0; STATUS[11:8] never > 8.
- RESULT read with FIFO empty → data 0, STATUS[4]=1; write STATUS=0x10 → STATUS[4]=0.
- Issue 3 ops, assert `wb_rst_i` 2 cycles after the 3rd → after reset STATUS=0x0000_0002; stray `exe_out[32]` pulses do not change res_count.
- Model drives `exe_out[32]`=0 at issue+LAT → STATUS[3]=1, FIFO entry 0, inflight returns to 0.
- IRQ_EN=1, one op issued → `irq` rises 1 cycle after res_count becomes 1; falls 1 cycle after the pop empties the FIFO; IRQ_EN=0 keeps `irq` low.
